seq_alu: RTL and testbench

Parametrised, multi-cycle successor to the core's single-cycle ALU. Executes logic and add/sub in one cycle and unsigned multiply/divide iteratively over N cycles behind a start/done handshake, with result and flags held stable until the next accepted operation. Sits in the execute stage; the pipeline stalls on `busy`.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/muldiv_iter.sv | 88 ++++++++
 rtl/seq_alu.sv | 165 ++++++++++++++++
 tb/tb_seq_alu.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state encoding and iterative-unit op kinds for seq_alu.
package alu_pkg;

  // ALU opcodes (4-bit sel field)
  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_MUL   = 4'b1000;
  localparam logic [3:0] OP_MULHU = 4'b1001;
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_REMU  = 4'b1101;

  // Control FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

  // Iterative unit op kind, equal to {sel[2], sel[0]} of the mul/div opcodes
  localparam logic [1:0] MD_MUL   = 2'b00;
  localparam logic [1:0] MD_MULHU = 2'b01;
  localparam logic [1:0] MD_DIVU  = 2'b10;
  localparam logic [1:0] MD_REMU  = 2'b11;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider, one step per cycle.
// {acc_hi, acc_lo} is the 2N-bit product accumulator for multiply; for divide
// acc_hi is the partial remainder and acc_lo shifts the dividend out and the quotient in.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic [1:0]   kind,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         last_c,
  output logic [N-1:0] result_c
);

  localparam int unsigned CW = $clog2(N) + 1;
  localparam int unsigned W1 = N + 1;
  localparam int unsigned W2 = N + 2;

  logic [N-1:0]  acc_hi;
  logic [N-1:0]  acc_lo;
  logic [N-1:0]  opb;
  logic [1:0]    op_kind;
  logic [CW-1:0] count;

  logic          is_div;
  logic          takes_hi;
  logic [W1-1:0] add_sum;
  logic [W1-1:0] shifted;
  logic [W2-1:0] diff;
  logic [N-1:0]  hi_nxt;
  logic [N-1:0]  lo_nxt;
  logic          unused_diff_bit;

  // Accumulator value after the current step, for both algorithms
  always_comb begin
    is_div   = (op_kind != MD_MUL) && (op_kind != MD_MULHU);
    takes_hi = (op_kind == MD_MULHU) || (op_kind == MD_REMU);
    add_sum  = W1'(acc_hi) + (acc_lo[0] ? W1'(opb) : W1'(0));
    shifted  = {acc_hi, acc_lo[N-1]};
    diff     = W2'(shifted) - W2'(opb);
    hi_nxt   = acc_hi;
    lo_nxt   = acc_lo;
    if (is_div) begin
      // A successful trial subtract always leaves a remainder that fits in N bits
      if (!diff[W2-1]) begin
        hi_nxt = diff[N-1:0];
        lo_nxt = {acc_lo[N-2:0], 1'b1};
      end else begin
        hi_nxt = shifted[N-1:0];
        lo_nxt = {acc_lo[N-2:0], 1'b0};
      end
    end else begin
      hi_nxt = add_sum[N:1];
      lo_nxt = {add_sum[0], acc_lo[N-1:1]};
    end
    last_c   = (count == CW'(N - 1));
    result_c = takes_hi ? hi_nxt : lo_nxt;
  end

  assign unused_diff_bit = diff[N];

  // Operand load and per-cycle iteration
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_hi  <= '0;
      acc_lo  <= '0;
      opb     <= '0;
      op_kind <= MD_MUL;
      count   <= '0;
    end else if (load) begin
      acc_hi  <= '0;
      acc_lo  <= a;
      opb     <= b;
      op_kind <= kind;
      count   <= '0;
    end else if (step) begin
      acc_hi  <= hi_nxt;
      acc_lo  <= lo_nxt;
      count   <= count + CW'(1);
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/add/sub, iterative unsigned mul/div
// behind a start/done handshake. Define SEQ_ALU_MULDIV_EN to build the
// mul/div datapath; otherwise those opcodes report illegal.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   sel,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         zero,
  output logic         carry,
  output logic         ovf,
  output logic         illegal
);

  localparam int unsigned W1 = N + 1;

  state_t       state;
  state_t       state_nxt;
  logic         done_nxt;
  logic [N-1:0] result_nxt;
  logic         zero_nxt;
  logic         carry_nxt;
  logic         ovf_nxt;
  logic         illegal_nxt;

  logic         is_sub;
  logic [N-1:0] b_eff;
  logic [W1-1:0] sum;
  logic [N-1:0] sc_result;
  logic         sc_carry;
  logic         sc_ovf;
  logic         sc_illegal;
  logic         sc_multi;

`ifdef SEQ_ALU_MULDIV_EN
  logic         md_load_c;
  logic         md_last_c;
  logic [N-1:0] md_result_c;

  muldiv_iter #(.N(N)) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .load     (md_load_c),
    .step     (state == S_RUN),
    .kind     ({sel[2], sel[0]}),
    .a        (A),
    .b        (B),
    .last_c   (md_last_c),
    .result_c (md_result_c)
  );
`endif

  // Single-cycle datapath and opcode decode, evaluated on the accepting edge
  always_comb begin
    is_sub     = (sel == OP_SUB);
    b_eff      = is_sub ? ~B : B;
    sum        = W1'(A) + W1'(b_eff) + W1'(is_sub);
    sc_result  = '0;
    sc_carry   = 1'b0;
    sc_ovf     = 1'b0;
    sc_illegal = 1'b0;
    sc_multi   = 1'b0;
    case (sel)
      OP_AND: sc_result = A & B;
      OP_OR:  sc_result = A | B;
      OP_XOR: sc_result = A ^ B;
      OP_ADD, OP_SUB: begin
        sc_result = sum[N-1:0];
        sc_carry  = sum[N];
        sc_ovf    = (A[N-1] == b_eff[N-1]) && (sum[N-1] != A[N-1]);
      end
`ifdef SEQ_ALU_MULDIV_EN
      OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: sc_multi = 1'b1;
`else
      OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: sc_illegal = 1'b1;
`endif
      default: sc_illegal = 1'b1;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt   = state;
    done_nxt    = 1'b0;
    result_nxt  = result;
    zero_nxt    = zero;
    carry_nxt   = carry;
    ovf_nxt     = ovf;
    illegal_nxt = illegal;
`ifdef SEQ_ALU_MULDIV_EN
    md_load_c   = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          if (sc_multi) begin
            state_nxt = S_RUN;
`ifdef SEQ_ALU_MULDIV_EN
            md_load_c = 1'b1;
`endif
          end else begin
            state_nxt   = S_DONE;
            done_nxt    = 1'b1;
            result_nxt  = sc_result;
            zero_nxt    = (sc_result == '0);
            carry_nxt   = sc_carry;
            ovf_nxt     = sc_ovf;
            illegal_nxt = sc_illegal;
          end
        end
      end
`ifdef SEQ_ALU_MULDIV_EN
      S_RUN: begin
        if (md_last_c) begin
          state_nxt   = S_DONE;
          done_nxt    = 1'b1;
          result_nxt  = md_result_c;
          zero_nxt    = (md_result_c == '0);
          carry_nxt   = 1'b0;
          ovf_nxt     = 1'b0;
          illegal_nxt = 1'b0;
        end
      end
`endif
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and registered outputs; reset discards any in-flight operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      zero    <= 1'b0;
      carry   <= 1'b0;
      ovf     <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready   <= (state_nxt == S_IDLE);
      busy    <= (state_nxt != S_IDLE);
      done    <= done_nxt;
      result  <= result_nxt;
      zero    <= zero_nxt;
      carry   <= carry_nxt;
      ovf     <= ovf_nxt;
      illegal <= illegal_nxt;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: the driver pushes expected responses, a monitor
// pops and checks them on every done pulse, including the cycle it arrives in.
module tb_seq_alu;
  import alu_pkg::*;

  localparam int unsigned N = 32;
`ifdef SEQ_ALU_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   sel;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         ready;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         zero;
  logic         carry;
  logic         ovf;
  logic         illegal;

  seq_alu #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .sel     (sel),
    .A       (A),
    .B       (B),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .zero    (zero),
    .carry   (carry),
    .ovf     (ovf),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           id;
    logic [N-1:0] res;
    logic         z;
    logic         c;
    logic         v;
    logic         il;
    int           due;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  // Monitor: every done pulse must match the oldest expected response
  exp_t me;
  always @(negedge clk) begin
    if (!rst && done) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: got result %08h at cycle %0d, want no done", result, cyc);
      end else begin
        me = sb.pop_front();
        if ({result, zero, carry, ovf, illegal} !== {me.res, me.z, me.c, me.v, me.il}) begin
          fails++;
          $display("FAIL op%0d_value: got res=%08h z=%0b c=%0b v=%0b il=%0b, want res=%08h z=%0b c=%0b v=%0b il=%0b",
                   me.id, result, zero, carry, ovf, illegal, me.res, me.z, me.c, me.v, me.il);
        end
        tests++;
        if (cyc != me.due) begin
          fails++;
          $display("FAIL op%0d_latency: done at cycle %0d, want %0d", me.id, cyc, me.due);
        end
        tests++;
        if (busy !== ~ready) begin
          fails++;
          $display("FAIL op%0d_busy: got busy=%0b ready=%0b, want busy=!ready", me.id, busy, ready);
        end
      end
    end
  end

  function automatic int lat_of(input bit md);
    return (md && MD_EN) ? int'(N) + 1 : 1;
  endfunction

  task automatic wait_ready(input int id);
    int k = 0;
    while (!ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!ready) begin
      tests++;
      fails++;
      $display("FAIL op%0d_ready_timeout: ready=%0b after %0d cycles, want 1", id, ready, k);
    end
  endtask

  task automatic push_exp(input int id, input logic [N-1:0] r, input logic z, input logic c,
                          input logic v, input logic il, input bit md, input int due);
    exp_t e;
    e.id = id;
    if (md && !MD_EN) begin
      e.res = '0; e.z = 1'b1; e.c = 1'b0; e.v = 1'b0; e.il = 1'b1;
    end else begin
      e.res = r; e.z = z; e.c = c; e.v = v; e.il = il;
    end
    e.due = due;
    sb.push_back(e);
  endtask

  // Issue one operation and check how long ready stays low afterwards
  task automatic issue(input int id, input logic [3:0] s, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] r, input logic z, input logic c, input logic v,
                       input logic il, input bit md);
    int lat;
    int n;
    wait_ready(id);
    lat = lat_of(md);
    push_exp(id, r, z, c, v, il, md, cyc + lat);
    start = 1'b1; sel = s; A = a; B = b;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    tests++;
    if (n != lat) begin
      fails++;
      $display("FAIL op%0d_busy_len: ready low %0d cycles, want %0d", id, n, lat);
    end
  endtask

  initial begin
    int c0;
    int n;
    rst = 1'b1; start = 1'b0; sel = 4'd0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({ready, busy, done, result, zero, carry, ovf, illegal} !== {1'b1, 1'b0, 1'b0, 32'h0, 4'b0000}) begin
      fails++;
      $display("FAIL reset_state: got rdy=%0b busy=%0b done=%0b res=%08h z=%0b c=%0b v=%0b il=%0b, want 1 0 0 0 0 0 0 0",
               ready, busy, done, result, zero, carry, ovf, illegal);
    end

    // Single-cycle operations
    issue(1,  OP_AND, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 0, 0, 0, 0, 0);
    issue(2,  OP_OR,  32'h0000F0F0, 32'h00000F0F, 32'h0000FFFF, 0, 0, 0, 0, 0);
    issue(3,  OP_XOR, 32'h0000FFFF, 32'h0000FFFF, 32'h00000000, 1, 0, 0, 0, 0);
    issue(4,  OP_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 1, 0, 0, 0);
    issue(5,  OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 0, 1, 0, 0);
    issue(6,  OP_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 0, 1, 1, 0, 0);
    issue(7,  OP_SUB, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 0, 0, 0, 0, 0);
    issue(8,  OP_SUB, 32'h00000007, 32'h00000007, 32'h00000000, 1, 1, 0, 0, 0);
    issue(9,  4'b0101, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1, 0, 0, 1, 0);
    issue(10, 4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1, 0, 0, 1, 0);
    // Legal op after illegal clears the flag
    issue(11, OP_ADD, 32'h00000003, 32'h00000004, 32'h00000007, 0, 0, 0, 0, 0);

    // Multi-cycle operations (illegal single-cycle when the mul/div unit is absent)
    issue(12, OP_MUL,   32'h00010000, 32'h00010000, 32'h00000000, 1, 0, 0, 0, 1);
    issue(13, OP_MULHU, 32'h00010000, 32'h00010000, 32'h00000001, 0, 0, 0, 0, 1);
    issue(14, OP_MUL,   32'h12345678, 32'h00000003, 32'h369D0368, 0, 0, 0, 0, 1);
    issue(15, OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 0, 0, 0, 1);
    issue(16, OP_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0, 0, 0, 0, 1);
    issue(17, OP_DIVU,  32'd100, 32'd7, 32'd14, 0, 0, 0, 0, 1);
    issue(18, OP_REMU,  32'd100, 32'd7, 32'd2,  0, 0, 0, 0, 1);
    issue(19, OP_DIVU,  32'd5,   32'd0, 32'hFFFFFFFF, 0, 0, 0, 0, 1);
    issue(20, OP_REMU,  32'd5,   32'd0, 32'd5,  0, 0, 0, 0, 1);
    issue(21, OP_DIVU,  32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 0, 0, 0, 0, 1);
    issue(22, OP_REMU,  32'd3,   32'd10, 32'd3, 0, 0, 0, 0, 1);

    // start held high with new operands while busy: ignored until ready returns
    wait_ready(23);
    c0 = cyc;
    push_exp(23, 32'd14, 0, 0, 0, 0, 1, c0 + lat_of(1));
    start = 1'b1; sel = OP_DIVU; A = 32'd100; B = 32'd7;
    @(negedge clk);
    sel = OP_AND; A = 32'h0000F0F0; B = 32'h00000FF0;
    n = 1;
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n != lat_of(1) + 1) begin
      fails++;
      $display("FAIL held_start_accept: ready returned after %0d cycles, want %0d", n, lat_of(1) + 1);
    end
    push_exp(24, 32'h000000F0, 0, 0, 0, 0, 0, cyc + 1);
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (ready !== 1'b0) begin
      fails++;
      $display("FAIL held_start_taken: ready=%0b after held accept, want 0", ready);
    end
    wait_ready(24);

    // Reset in the middle of a divide discards it
    wait_ready(25);
    if (!MD_EN) push_exp(25, '0, 1, 0, 0, 1, 1, cyc + 1);
    start = 1'b1; sel = OP_DIVU; A = 32'd100; B = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({ready, busy, done, result, zero, carry, ovf, illegal} !== {1'b1, 1'b0, 1'b0, 32'h0, 4'b0000}) begin
      fails++;
      $display("FAIL mid_run_reset: got rdy=%0b busy=%0b done=%0b res=%08h z=%0b c=%0b v=%0b il=%0b, want 1 0 0 0 0 0 0 0",
               ready, busy, done, result, zero, carry, ovf, illegal);
    end
    issue(26, OP_AND, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 0, 0, 0, 0, 0);

    repeat (N + 4) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: simulation still running at time %0t, want finished", $time);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
